// File: rtl/acc_pkg.sv
// Shared encodings and the DW saturation helper for the multi-channel
// accumulator/output stage.
package acc_pkg;

   localparam logic MODE_CH  = 1'b0;
   localparam logic MODE_SUM = 1'b1;

   typedef enum logic {
      ST_ACC  = 1'b0,
      ST_HOLD = 1'b1
   } ch_state_e;

   // Wide enough for any AW + clog2(NUM_CH) this block is built with
   localparam int SAT_W = 128;

   typedef struct packed {
      logic             clamped;
      logic [SAT_W-1:0] value;
   } sat_t;

   function automatic sat_t sat_to_dw(input logic signed [SAT_W-1:0] v, input int unsigned dw);
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      sat_t                    r;
      hi = $signed((SAT_W'(1) << (dw - 32'd1)) - SAT_W'(1));
      lo = ~hi;
      r.clamped = 1'b0;
      r.value   = v;
      if (v > hi) begin
         r.clamped = 1'b1;
         r.value   = hi;
      end else if (v < lo) begin
         r.clamped = 1'b1;
         r.value   = lo;
      end else begin
         r.clamped = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/acc_lane.sv
// One accumulator channel: ACC/HOLD FSM, AW-wide accumulator with sticky
// overflow, and the registered saturated result.
module acc_lane
   import acc_pkg::*;
#(
   parameter int DW = 32,
   parameter int AW = 40
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mode_q_i,
   input  logic                 in_valid_i,
   input  logic [DW-1:0]        in_data_i,
   input  logic                 in_last_i,
   input  logic                 clear_i,
   input  logic                 out_ready_i,
   input  logic                 release_i,
   output logic                 in_ready_o,
   output logic                 hold_o,
   output logic                 out_valid_o,
   output logic [DW-1:0]        out_data_o,
   output logic                 out_sat_o,
   output logic signed [AW-1:0] res_o
);

   localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
   localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

   ch_state_e               state_q, state_d;
   logic signed [AW-1:0]    acc_q, acc_d;
   logic signed [AW-1:0]    res_q, res_d;
   logic                    ovf_q, ovf_d;
   logic [DW-1:0]           out_data_q, out_data_d;
   logic                    out_sat_q, out_sat_d;

   logic signed [DW-1:0]    data_s;
   logic signed [AW-1:0]    data_ext_s;
   logic signed [AW-1:0]    acc_base_s;
   logic [AW:0]             sum_w_s;
   logic                    aw_ovf_s;
   logic signed [AW-1:0]    acc_sum_s;
   sat_t                    res_sat_s;
   logic                    accept_s;
   logic                    leave_s;

   // Clear takes effect before the same-cycle beat is added
   always_comb begin
      data_s     = in_data_i;
      data_ext_s = AW'(data_s);
      acc_base_s = clear_i ? {AW{1'b0}} : acc_q;
      sum_w_s    = {acc_base_s[AW-1], acc_base_s} + {data_ext_s[AW-1], data_ext_s};
      aw_ovf_s   = sum_w_s[AW] ^ sum_w_s[AW-1];
      if (aw_ovf_s) begin
         acc_sum_s = sum_w_s[AW] ? ACC_MIN : ACC_MAX;
      end else begin
         acc_sum_s = sum_w_s[AW-1:0];
      end
      res_sat_s = sat_to_dw(SAT_W'(acc_sum_s), DW);
      accept_s  = (state_q == ST_ACC) && in_valid_i;
      leave_s   = (state_q == ST_HOLD) && ((mode_q_i == MODE_CH) ? out_ready_i : release_i);
   end

   // Next-state for FSM, accumulator, overflow and result registers
   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      ovf_d      = ovf_q;
      res_d      = res_q;
      out_data_d = out_data_q;
      out_sat_d  = out_sat_q;
      case (state_q)
         ST_ACC: begin
            if (accept_s) begin
               ovf_d = (ovf_q & ~clear_i) | aw_ovf_s;
               if (in_last_i) begin
                  acc_d      = {AW{1'b0}};
                  res_d      = acc_sum_s;
                  out_data_d = DW'(res_sat_s.value);
                  out_sat_d  = ovf_d | res_sat_s.clamped;
                  state_d    = ST_HOLD;
               end else begin
                  acc_d = acc_sum_s;
               end
            end else if (clear_i) begin
               acc_d = {AW{1'b0}};
               ovf_d = 1'b0;
            end else begin
               acc_d = acc_q;
            end
         end
         ST_HOLD: begin
            if (clear_i) begin
               acc_d = {AW{1'b0}};
            end else begin
               acc_d = acc_q;
            end
            if (leave_s) begin
               state_d = ST_ACC;
               ovf_d   = 1'b0;
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: begin
            state_d = ST_ACC;
         end
      endcase
   end

   // Lane state registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_ACC;
         acc_q      <= {AW{1'b0}};
         res_q      <= {AW{1'b0}};
         ovf_q      <= 1'b0;
         out_data_q <= {DW{1'b0}};
         out_sat_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         res_q      <= res_d;
         ovf_q      <= ovf_d;
         out_data_q <= out_data_d;
         out_sat_q  <= out_sat_d;
      end
   end

   assign in_ready_o  = (state_q == ST_ACC);
   assign hold_o      = (state_q == ST_HOLD);
   assign out_valid_o = (state_q == ST_HOLD) && (mode_q_i == MODE_CH);
   assign out_data_o  = out_data_q;
   assign out_sat_o   = out_sat_q;
   assign res_o       = res_q;

endmodule

// File: rtl/acc_out_array.sv
// Multi-channel accumulator/output stage: NUM_CH independent lanes plus a
// cross-channel total with its own handshake.
module acc_out_array
   import acc_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int DW     = 32,
   parameter int AW     = 40
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mode_i,
   input  logic [NUM_CH-1:0]    in_valid_i,
   output logic [NUM_CH-1:0]    in_ready_o,
   input  logic [NUM_CH*DW-1:0] in_data_i,
   input  logic [NUM_CH-1:0]    in_last_i,
   input  logic [NUM_CH-1:0]    clear_i,
   output logic [NUM_CH-1:0]    out_valid_o,
   input  logic [NUM_CH-1:0]    out_ready_i,
   output logic [NUM_CH*DW-1:0] out_data_o,
   output logic [NUM_CH-1:0]    out_sat_o,
   output logic                 total_valid_o,
   input  logic                 total_ready_i,
   output logic [DW-1:0]        total_data_o,
   output logic                 total_sat_o
);

   localparam int TW = AW + $clog2(NUM_CH);

   logic                 mode_q;
   logic                 total_valid_q;
   logic [DW-1:0]        total_data_q;
   logic                 total_sat_q;

   logic [NUM_CH-1:0]    hold_s;
   logic signed [AW-1:0] res_s [NUM_CH];
   logic signed [TW-1:0] sum_s;
   sat_t                 tot_sat_s;
   logic                 release_s;
   logic                 all_acc_s;
   logic                 all_hold_s;

   assign release_s  = total_valid_q & total_ready_i;
   assign all_acc_s  = &in_ready_o;
   assign all_hold_s = &hold_s;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
      acc_lane #(
         .DW (DW),
         .AW (AW)
      ) u_lane (
         .clk         (clk),
         .rst         (rst),
         .mode_q_i    (mode_q),
         .in_valid_i  (in_valid_i[c]),
         .in_data_i   (in_data_i[c*DW +: DW]),
         .in_last_i   (in_last_i[c]),
         .clear_i     (clear_i[c]),
         .out_ready_i (out_ready_i[c]),
         .release_i   (release_s),
         .in_ready_o  (in_ready_o[c]),
         .hold_o      (hold_s[c]),
         .out_valid_o (out_valid_o[c]),
         .out_data_o  (out_data_o[c*DW +: DW]),
         .out_sat_o   (out_sat_o[c]),
         .res_o       (res_s[c])
      );
   end

   // Total is formed at full precision so only the final DW clamp can saturate
   always_comb begin
      sum_s = {TW{1'b0}};
      for (int c = 0; c < NUM_CH; c++) begin
         sum_s = sum_s + TW'(res_s[c]);
      end
      tot_sat_s = sat_to_dw(SAT_W'(sum_s), DW);
   end

   // Mode register and total handshake
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_q        <= MODE_CH;
         total_valid_q <= 1'b0;
         total_data_q  <= {DW{1'b0}};
         total_sat_q   <= 1'b0;
      end else begin
         if (all_acc_s) begin
            mode_q <= mode_i;
         end else begin
            mode_q <= mode_q;
         end
         if ((mode_q == MODE_SUM) && all_hold_s && !total_valid_q) begin
            total_valid_q <= 1'b1;
            total_data_q  <= DW'(tot_sat_s.value);
            total_sat_q   <= tot_sat_s.clamped | (|out_sat_o);
         end else if (release_s) begin
            total_valid_q <= 1'b0;
         end else begin
            total_valid_q <= total_valid_q;
         end
      end
   end

   assign total_valid_o = total_valid_q;
   assign total_data_o  = total_data_q;
   assign total_sat_o   = total_sat_q;

endmodule

// File: tb/tb_acc_out_array.sv
// Directed self-checking bench for acc_out_array (NUM_CH=4, DW=32, AW=40).
module tb_acc_out_array;

   logic         clk;
   logic         rst;
   logic         mode;
   logic [3:0]   in_valid;
   logic [3:0]   in_ready;
   logic [127:0] in_data;
   logic [3:0]   in_last;
   logic [3:0]   clear;
   logic [3:0]   out_valid;
   logic [3:0]   out_ready;
   logic [127:0] out_data;
   logic [3:0]   out_sat;
   logic         total_valid;
   logic         total_ready;
   logic [31:0]  total_data;
   logic         total_sat;

   int checks;
   int errors;

   acc_out_array #(.NUM_CH(4), .DW(32), .AW(40)) dut (
      .clk           (clk),
      .rst           (rst),
      .mode_i        (mode),
      .in_valid_i    (in_valid),
      .in_ready_o    (in_ready),
      .in_data_i     (in_data),
      .in_last_i     (in_last),
      .clear_i       (clear),
      .out_valid_o   (out_valid),
      .out_ready_i   (out_ready),
      .out_data_o    (out_data),
      .out_sat_o     (out_sat),
      .total_valid_o (total_valid),
      .total_ready_i (total_ready),
      .total_data_o  (total_data),
      .total_sat_o   (total_sat)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Present one beat on channel c for exactly one clock edge
   task automatic send(input int c, input logic [31:0] d, input logic last, input logic clr);
      in_valid[c]          = 1'b1;
      in_data[c*32 +: 32]  = d;
      in_last[c]           = last;
      clear[c]             = clr;
      @(posedge clk); #1;
      in_valid[c] = 1'b0;
      in_last[c]  = 1'b0;
      clear[c]    = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (in_ready !== 4'hF) begin errors++; $display("FAIL reset_in_ready got %h exp %h", in_ready, 4'hF); end
      checks++;
      if ({out_valid, out_sat, total_valid, total_sat} !== 10'h000) begin
         errors++; $display("FAIL reset_flags got %h exp %h", {out_valid, out_sat, total_valid, total_sat}, 10'h000);
      end
      checks++;
      if ({out_data, total_data} !== 160'h0) begin errors++; $display("FAIL reset_data got %h exp 0", {out_data, total_data}); end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_ch_basic();
      send(0, 32'd5, 1'b0, 1'b0);
      send(0, 32'd7, 1'b0, 1'b0);
      send(0, 32'hFFFFFFFE, 1'b1, 1'b0);
      checks++;
      if (out_valid !== 4'b0001) begin errors++; $display("FAIL basic_valid got %b exp %b", out_valid, 4'b0001); end
      checks++;
      if (out_data[31:0] !== 32'd10) begin errors++; $display("FAIL basic_data got %h exp %h", out_data[31:0], 32'd10); end
      checks++;
      if (out_sat[0] !== 1'b0) begin errors++; $display("FAIL basic_sat got %b exp 0", out_sat[0]); end
      checks++;
      if (in_ready !== 4'b1110) begin errors++; $display("FAIL basic_in_ready got %b exp %b", in_ready, 4'b1110); end
      tick();
      checks++;
      if ({out_valid, in_ready} !== 8'h0F) begin errors++; $display("FAIL basic_drain got %h exp %h", {out_valid, in_ready}, 8'h0F); end
   endtask

   task automatic test_ch_saturate();
      out_ready[1] = 1'b0;
      send(1, 32'h7FFFFFFF, 1'b0, 1'b0);
      send(1, 32'h7FFFFFFF, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({out_valid[1], in_ready[1], out_sat[1], out_data[63:32]} !== {3'b101, 32'h7FFFFFFF}) begin
            errors++;
            $display("FAIL sat_hold cyc %0d got v=%b rdy=%b sat=%b d=%h exp v=1 rdy=0 sat=1 d=7fffffff",
                     i, out_valid[1], in_ready[1], out_sat[1], out_data[63:32]);
         end
         tick();
      end
      out_ready[1] = 1'b1;
      tick();
      checks++;
      if (out_valid[1] !== 1'b0) begin errors++; $display("FAIL sat_drain got %b exp 0", out_valid[1]); end
   endtask

   task automatic test_sum_total();
      mode        = 1'b1;
      total_ready = 1'b0;
      tick();
      send(0, 32'd1, 1'b1, 1'b0);
      tick();
      send(1, 32'd2, 1'b1, 1'b0);
      send(2, 32'd3, 1'b1, 1'b0);
      tick();
      send(3, 32'd4, 1'b1, 1'b0);
      checks++;
      if ({total_valid, out_valid} !== 5'b0_0000) begin errors++; $display("FAIL sum_early got %b exp 00000", {total_valid, out_valid}); end
      tick();
      checks++;
      if ({total_valid, total_sat, total_data} !== {2'b10, 32'd10}) begin
         errors++; $display("FAIL sum_total got v=%b s=%b d=%h exp v=1 s=0 d=0000000a", total_valid, total_sat, total_data);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({in_ready, total_valid, total_data} !== {5'b0000_1, 32'd10}) begin
            errors++; $display("FAIL sum_hold cyc %0d got rdy=%b v=%b d=%h exp rdy=0000 v=1 d=0000000a", i, in_ready, total_valid, total_data);
         end
      end
      total_ready = 1'b1;
      mode        = 1'b0;
      tick();
      total_ready = 1'b0;
      checks++;
      if ({total_valid, in_ready} !== 5'b0_1111) begin errors++; $display("FAIL sum_release got %b exp 01111", {total_valid, in_ready}); end
      tick();
   endtask

   task automatic test_clear();
      send(2, 32'd100, 1'b0, 1'b0);
      send(2, 32'd9, 1'b0, 1'b1);
      send(2, 32'd1, 1'b1, 1'b0);
      checks++;
      if ({out_valid[2], out_data[95:64]} !== {1'b1, 32'd10}) begin
         errors++; $display("FAIL clear_result got v=%b d=%h exp v=1 d=0000000a", out_valid[2], out_data[95:64]);
      end
      tick();
   endtask

   task automatic test_mode_switch();
      out_ready[0] = 1'b0;
      send(0, 32'd4, 1'b1, 1'b0);
      mode = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (out_valid[0] !== 1'b1) begin errors++; $display("FAIL mode_held cyc %0d got %b exp 1", i, out_valid[0]); end
      end
      out_ready[0] = 1'b1;
      tick();
      tick();
      send(0, 32'd5, 1'b1, 1'b0);
      checks++;
      if ({out_valid[0], in_ready[0]} !== 2'b00) begin errors++; $display("FAIL mode_switched got %b exp 00", {out_valid[0], in_ready[0]}); end
      send(1, 32'd0, 1'b1, 1'b0);
      send(2, 32'd0, 1'b1, 1'b0);
      total_ready = 1'b1;
      send(3, 32'd0, 1'b1, 1'b0);
      tick();
      checks++;
      if ({total_valid, total_data} !== {1'b1, 32'd5}) begin errors++; $display("FAIL mode_total got v=%b d=%h exp v=1 d=00000005", total_valid, total_data); end
      mode = 1'b0;
      tick();
      total_ready = 1'b0;
      checks++;
      if (total_valid !== 1'b0) begin errors++; $display("FAIL mode_release got %b exp 0", total_valid); end
      tick();
   endtask

   task automatic test_async_reset();
      send(0, 32'd50, 1'b0, 1'b0);
      out_ready[1] = 1'b0;
      send(1, 32'd7, 1'b1, 1'b0);
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({in_ready, out_valid, out_sat, total_valid} !== 13'b1111_0000_0000_0) begin
         errors++; $display("FAIL rst_flags got rdy=%b v=%b s=%b tv=%b exp rdy=1111 v=0000 s=0000 tv=0", in_ready, out_valid, out_sat, total_valid);
      end
      checks++;
      if (out_data !== 128'h0) begin errors++; $display("FAIL rst_data got %h exp 0", out_data); end
      @(posedge clk); #1;
      rst          = 1'b1;
      out_ready    = 4'hF;
      send(0, 32'd3, 1'b1, 1'b0);
      checks++;
      if ({out_valid[0], out_data[31:0]} !== {1'b1, 32'd3}) begin
         errors++; $display("FAIL rst_after got v=%b d=%h exp v=1 d=00000003", out_valid[0], out_data[31:0]);
      end
      tick();
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      rst         = 1'b0;
      mode        = 1'b0;
      in_valid    = 4'h0;
      in_data     = 128'h0;
      in_last     = 4'h0;
      clear       = 4'h0;
      out_ready   = 4'hF;
      total_ready = 1'b0;
      test_reset();
      test_ch_basic();
      test_ch_saturate();
      test_sum_total();
      test_clear();
      test_mode_switch();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/acc_out_array.md
Name: acc_out_array

Overview:
Parametrised multi-channel accumulator and output stage, the successor of the fixed 4-channel result accumulator. It sits between the PE array's partial-sum outputs and the writeback path.
- Each channel accumulates a stream of signed partial sums and closes a result on a last flag.
- The closed result is presented either per channel or as a cross-channel total, using valid/ready handshakes on both sides.
- Results saturate to the output width; each result carries an overflow flag.

Parameters:
NUM_CH, 4, number of independent channels (>=1)
DW, 32, input/output data width, signed two's complement
AW, 40, internal accumulator width (AW >= DW)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
mode  in  1  0 = per-channel results, 1 = cross-channel total; sampled only when all channels are in ACC
in_valid  in  NUM_CH  per-channel input valid
in_ready  out  NUM_CH  per-channel input ready
in_data  in  NUM_CH*DW  channel c occupies bits [c*DW +: DW]
in_last  in  NUM_CH  marks the final operand of the current result
clear  in  NUM_CH  zero the channel accumulator
out_valid  out  NUM_CH  per-channel result valid (mode 0 only)
out_ready  in  NUM_CH  per-channel result ready
out_data  out  NUM_CH*DW  saturated per-channel results
out_sat  out  NUM_CH  result was saturated, or the accumulator overflowed AW
total_valid  out  1  cross-channel total valid (mode 1 only)
total_ready  in  1  total ready
total_data  out  DW  saturated sum of all channel results
total_sat  out  1  total saturated, or any contributing channel flag set

Behaviour:
- Reset (rst low, async): all channels go to ACC, accumulators 0, mode_q 0. All outputs 0 except in_ready, which is all 1s.
- mode_q: loaded from mode on any clk edge where every channel is in ACC. Otherwise held.
- Per-channel FSM, two states:
  - ACC: in_ready[c]=1. A beat is accepted when in_valid & in_ready.
  - Accept with in_last=0: acc <= acc + sext(data). Stay in ACC.
  - Accept with in_last=1: res <= acc + sext(data); acc <= 0; go to HOLD.
  - HOLD: in_ready[c]=0. res is held stable.
- Result path, mode_q=0: out_valid[c]=1 in HOLD. On out_valid & out_ready, return to ACC on the next edge. Latency: last beat accepted at edge T gives out_valid high after T; earliest next accept is edge T+2.
- Result path, mode_q=1: out_valid stays 0.
  - When every channel is in HOLD, register total = sum of all res at AW+clog2(NUM_CH) width, saturated to DW. total_valid rises one cycle after the last channel enters HOLD.
  - On total_valid & total_ready, all channels return to ACC together and total_valid drops.
- Saturation: res is clamped to [-2^(DW-1), 2^(DW-1)-1] on out_data.
  - AW overflow in acc (sign-based detect) sets a sticky per-channel ovf bit and clamps acc to the AW limits.
  - out_sat = ovf | clamp applied. ovf clears when the result leaves HOLD.
- clear[c]:
  - In ACC: acc is zeroed. clear with a same-cycle accepted beat gives acc = sext(data) (clear first); with last, res = sext(data). ovf is cleared.
  - In HOLD: acc is zeroed; res and out_sat are unaffected.
- Channels are independent in mode 0: simultaneous lasts and handshakes on different channels do not interact.
- Held outputs: data, flag and valid outputs are registered and stable while valid & !ready.

Decomposition:
- Shared package acc_pkg holds:
  - mode encodings MODE_CH=1'b0, MODE_SUM=1'b1
  - channel state encodings ST_ACC, ST_HOLD
  - a saturate-to-DW function
- Natural sub-module acc_lane: one channel's FSM, accumulator, ovf and res register. Instantiated NUM_CH times in a generate loop.
- The top level holds mode_q, the total adder tree and the total handshake.

Test Plan:
- Mode 0, ch0 beats 5, 7, -2(last), out_ready=1 -> out_valid[0] one cycle after the last beat, out_data[0]=10, out_sat[0]=0; other channels idle with in_ready=1.
- Mode 0, ch1 beats 0x7FFFFFFF, 0x7FFFFFFF(last) -> out_data[1]=0x7FFFFFFF, out_sat[1]=1. Hold out_ready=0 for 5 cycles -> data, valid and in_ready[1]=0 all stable.
- Mode 1, channels close 1, 2, 3, 4 on different cycles -> total_valid one cycle after the fourth last, total_data=10. total_ready held 0 for 3 cycles -> all in_ready stay 0.
- clear[2] asserted with an accepted beat of 9 after a prior partial sum of 100, then last beat 1 -> out_data[2]=10.
- Assert mode=1 while ch0 is in HOLD -> mode_q stays 0 until ch0 is drained, then switches.
- Assert rst low mid-accumulation and while HOLD -> all outputs 0, in_ready all 1s; after release, ch0 beat 3(last) -> out_data[0]=3.
